emulador_hcsr04: RTL and testbench



---
 rtl/aqua_sensor_pkg.sv | 31 +++
 rtl/sincroniza_borda.sv | 32 +++
 rtl/emulador_hcsr04.sv | 141 ++++++++++++++
 tb/tb_emulador_hcsr04.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aqua_sensor_pkg.sv
// Shared definitions for the AQUA ultrasonic sensor path: state encoding,
// default timing constants and the distance clamp.
package aqua_sensor_pkg;

  typedef enum logic [2:0] {
    REPOUSO   = 3'd0,
    MEDE_TRIG = 3'd1,
    ATRASO    = 3'd2,
    ECHO      = 3'd3,
    HOLDOFF   = 3'd4
  } estado_t;

  localparam int DEF_TICKS_PER_US  = 50;
  localparam int DEF_TRIG_MIN_US   = 10;
  localparam int DEF_ECHO_DELAY_US = 400;
  localparam int DEF_TICKS_PER_CM  = 2941;
  localparam int DEF_MIN_CM        = 2;
  localparam int DEF_MAX_CM        = 400;
  localparam int DEF_TIMEOUT_US    = 38000;
  localparam int DEF_HOLDOFF_US    = 1000;

  // Wide enough for the 38 ms timeout at 50 MHz (1_900_000 ticks).
  localparam int CNT_W = 21;

  function automatic logic [8:0] clamp_cm(input logic [8:0] d, input int lo, input int hi);
    if (int'(d) < lo) return 9'(lo);
    if (int'(d) > hi) return 9'(hi);
    return d;
  endfunction

endpackage

// File: rtl/sincroniza_borda.sv
// Two-flop synchronizer for an asynchronous input, with one-cycle rise and
// fall pulses taken from the synchronized level.
module sincroniza_borda (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic nivel_o,
  output logic sobe_o,
  output logic desce_o
);

  logic meta_q;
  logic sinc_q;
  logic ant_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sinc_q <= 1'b0;
      ant_q  <= 1'b0;
    end else begin
      meta_q <= d_i;
      sinc_q <= meta_q;
      ant_q  <= sinc_q;
    end
  end

  assign nivel_o = sinc_q;
  assign sobe_o  = sinc_q & ~ant_q;
  assign desce_o = ~sinc_q & ant_q;

endmodule

// File: rtl/emulador_hcsr04.sv
// HC-SR04 responder: measures the trigger pulse, waits the flight delay and
// returns an echo whose width encodes the programmed distance.
module emulador_hcsr04
  import aqua_sensor_pkg::*;
#(
  parameter int TICKS_PER_US  = DEF_TICKS_PER_US,
  parameter int TRIG_MIN_US   = DEF_TRIG_MIN_US,
  parameter int ECHO_DELAY_US = DEF_ECHO_DELAY_US,
  parameter int TICKS_PER_CM  = DEF_TICKS_PER_CM,
  parameter int MIN_CM        = DEF_MIN_CM,
  parameter int MAX_CM        = DEF_MAX_CM,
  parameter int TIMEOUT_US    = DEF_TIMEOUT_US,
  parameter int HOLDOFF_US    = DEF_HOLDOFF_US
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia_cm,
  input  logic       presente,
  output logic       echo,
  output logic       ocupado,
  output logic       trigger_ignorado,
  output logic [2:0] db_estado
);

  localparam int TRIG_MIN = TRIG_MIN_US * TICKS_PER_US;
  localparam int DELAY    = ECHO_DELAY_US * TICKS_PER_US;
  localparam int TIMEOUT  = TIMEOUT_US * TICKS_PER_US;
  localparam int HOLD     = HOLDOFF_US * TICKS_PER_US;

  localparam logic [CNT_W-1:0] TRIG_MIN_C   = CNT_W'(TRIG_MIN);
  // The rise cycle itself is the first high tick, so the count trails the
  // true high time by one when the fall is seen.
  localparam logic [CNT_W-1:0] TRIG_ACEITA_C = CNT_W'(TRIG_MIN - 1);
  localparam logic [CNT_W-1:0] DELAY_FIM_C   = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_FIM_C    = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C     = CNT_W'(TIMEOUT);

  estado_t            state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   width_q, width_d;
  logic               echo_q, echo_d;
  logic               ign_q, ign_d;
  logic               trig_nivel, trig_sobe, trig_desce;
  logic [CNT_W-1:0]   largura_dist;

  sincroniza_borda u_sinc (
    .clk_i   (clock),
    .rst_ni  (reset),
    .d_i     (trigger),
    .nivel_o (trig_nivel),
    .sobe_o  (trig_sobe),
    .desce_o (trig_desce)
  );

  assign largura_dist = CNT_W'(int'(clamp_cm(distancia_cm, MIN_CM, MAX_CM)) * TICKS_PER_CM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= REPOUSO;
      cnt_q   <= '0;
      width_q <= '0;
      echo_q  <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      echo_q  <= echo_d;
      ign_q   <= ign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    ign_d   = 1'b0;
    case (state_q)
      REPOUSO: begin
        if (trig_sobe) begin
          state_d = MEDE_TRIG;
          cnt_d   = '0;
        end
      end
      MEDE_TRIG: begin
        if (trig_desce) begin
          cnt_d = '0;
          if (cnt_q >= TRIG_ACEITA_C) begin
            state_d = ATRASO;
            width_d = presente ? largura_dist : TIMEOUT_C;
          end else begin
            state_d = REPOUSO;
          end
        end else if (trig_nivel && (cnt_q < TRIG_MIN_C)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ATRASO: begin
        ign_d = trig_sobe;
        if (cnt_q == DELAY_FIM_C) begin
          state_d = ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ECHO: begin
        ign_d = trig_sobe;
        if (cnt_q == width_q - CNT_W'(1)) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLDOFF: begin
        ign_d = trig_sobe;
        if (cnt_q == HOLD_FIM_C) begin
          state_d = REPOUSO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = REPOUSO;
        cnt_d   = '0;
      end
    endcase
    echo_d = (state_d == ECHO);
  end

  always_comb begin
    echo             = echo_q;
    ocupado          = (state_q != REPOUSO);
    trigger_ignorado = ign_q;
    db_estado        = state_q;
  end

endmodule

// File: tb/tb_emulador_hcsr04.sv
// Bench for emulador_hcsr04 with shortened timing so full measurements fit
// in a short run; a timestamp-based model predicts every output cycle by cycle.
module tb_emulador_hcsr04;

  localparam int T_US     = 2;
  localparam int TRIG_US  = 10;
  localparam int DELAY_US = 20;
  localparam int TPCM     = 3;
  localparam int MINCM    = 2;
  localparam int MAXCM    = 400;
  localparam int TMO_US   = 700;
  localparam int HOLD_US  = 30;

  localparam int P_TRIG    = TRIG_US * T_US;
  localparam int P_DELAY   = DELAY_US * T_US;
  localparam int P_TIMEOUT = TMO_US * T_US;
  localparam int P_HOLD    = HOLD_US * T_US;

  logic       clock;
  logic       reset;
  logic       trigger;
  logic [8:0] distancia_cm;
  logic       presente;
  logic       echo;
  logic       ocupado;
  logic       trigger_ignorado;
  logic [2:0] db_estado;

  emulador_hcsr04 #(
    .TICKS_PER_US  (T_US),
    .TRIG_MIN_US   (TRIG_US),
    .ECHO_DELAY_US (DELAY_US),
    .TICKS_PER_CM  (TPCM),
    .MIN_CM        (MINCM),
    .MAX_CM        (MAXCM),
    .TIMEOUT_US    (TMO_US),
    .HOLDOFF_US    (HOLD_US)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .trigger          (trigger),
    .distancia_cm     (distancia_cm),
    .presente         (presente),
    .echo             (echo),
    .ocupado          (ocupado),
    .trigger_ignorado (trigger_ignorado),
    .db_estado        (db_estado)
  );

  // ---------------- clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (absolute timestamps of each phase)
  longint cyc = 0;
  longint t_start = 0;
  longint t_fall = 0;
  int     m_w = 0;
  bit     m_busy = 0;
  bit     m_acc = 0;
  bit     ign_exp = 0;
  bit     p1 = 0, p2 = 0, p3 = 0;

  function automatic int exp_width(input int d, input bit pres);
    int c;
    if (!pres) return P_TIMEOUT;
    c = d;
    if (c < MINCM) c = MINCM;
    if (c > MAXCM) c = MAXCM;
    return c * TPCM;
  endfunction

  function automatic int state_at(input longint c);
    if (!m_busy) return 0;
    if (!m_acc) return 1;
    if (c < t_fall + P_DELAY) return 2;
    if (c < t_fall + P_DELAY + m_w) return 3;
    if (c < t_fall + P_DELAY + m_w + P_HOLD) return 4;
    return 0;
  endfunction

  initial begin
    bit rise, fall;
    int ps;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        p1 = 0; p2 = 0; p3 = 0;
        m_busy = 0; m_acc = 0; ign_exp = 0;
      end else begin
        cyc++;
        // the synchronized view of the pin lags the pin by two samples
        rise = p2 && !p3;
        fall = !p2 && p3;
        ps = state_at(cyc - 1);
        ign_exp = rise && (ps >= 2);
        if (ps == 0 && rise) begin
          m_busy = 1; m_acc = 0; t_start = cyc;
        end else if (ps == 1 && fall) begin
          if (cyc - t_start >= P_TRIG) begin
            m_acc = 1; t_fall = cyc; m_w = exp_width(int'(distancia_cm), presente);
          end else begin
            m_busy = 0;
          end
        end
        p3 = p2; p2 = p1; p1 = trigger;
      end
    end
  end

  // ---------------- per-cycle compare against the model
  bit cmp_en = 0;
  initial begin
    int st;
    forever begin
      @(negedge clock);
      if (cmp_en) begin
        st = state_at(cyc);
        check("cmp_db_estado", db_estado, st);
        check("cmp_echo", echo, (st == 3) ? 1 : 0);
        check("cmp_ocupado", ocupado, (st != 0) ? 1 : 0);
        check("cmp_trigger_ignorado", trigger_ignorado, ign_exp);
      end
    end
  end

  // ---------------- echo / ignore monitor
  int run_w = 0, last_w = 0, n_echo = 0, n_ign = 0;
  initial begin
    forever begin
      @(negedge clock);
      if (echo === 1'b1) run_w++;
      else if (run_w > 0) begin
        last_w = run_w; n_echo++; run_w = 0;
      end
      if (trigger_ignorado === 1'b1) n_ign++;
    end
  end

  // ---------------- driver tasks
  task automatic do_pulse(input int n);
    @(negedge clock);
    trigger = 1'b1;
    repeat (n) @(negedge clock);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (!ocupado) break;
    end
    check("idle_reached", ocupado, 0);
  endtask

  task automatic wait_echo(input logic val, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (echo == val) break;
    end
    check("echo_level_reached", echo, val);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- directed and random stimulus
  int dist_tab[5] = '{100, 20, 0, 511, 74};
  int pres_tab[5] = '{1, 1, 1, 1, 0};
  int wid_tab[5]  = '{300, 60, 6, 1200, 1400};

  initial begin
    int lat, w, h, e0, i0, n;
    reset = 1'b0;
    trigger = 1'b0;
    distancia_cm = 9'd74;
    presente = 1'b1;
    #1 cmp_en = 1;
    repeat (3) @(negedge clock);
    check("reset_echo", echo, 0);
    check("reset_ocupado", ocupado, 0);
    check("reset_ign", trigger_ignorado, 0);
    check("reset_estado", db_estado, 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // minimum-length trigger, 74 cm: latency, width and holdoff pinned
    do_pulse(P_TRIG);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1; lat++;
      if (echo) break;
    end
    check("latency_74", lat, 43);
    w = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clock); #1; w++;
      if (!echo) break;
    end
    check("width_74", w, 222);
    h = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clock); #1; h++;
      if (!ocupado) break;
    end
    check("holdoff_74", h, 60);

    // distance table including both clamps and the timeout echo
    for (int k = 0; k < 5; k++) begin
      distancia_cm = 9'(dist_tab[k]);
      presente = pres_tab[k][0];
      e0 = n_echo;
      do_pulse(P_TRIG);
      wait_idle(4000);
      check($sformatf("width_d%0d_p%0d", dist_tab[k], pres_tab[k]), last_w, wid_tab[k]);
      check("one_echo_table", n_echo, e0 + 1);
    end
    presente = 1'b1;

    // glitch rejection: 5 us pulse and one tick short of the minimum
    e0 = n_echo; i0 = n_ign;
    do_pulse(10);
    repeat (20) @(negedge clock);
    do_pulse(P_TRIG - 1);
    repeat (20) @(negedge clock);
    check("glitch_no_echo", n_echo, e0);
    check("glitch_no_ign", n_ign, i0);
    check("glitch_estado", db_estado, 0);

    // busy trigger and input changes during the echo
    distancia_cm = 9'd50;
    e0 = n_echo; i0 = n_ign;
    do_pulse(P_TRIG);
    wait_echo(1'b1, 200);
    distancia_cm = 9'd300;
    presente = 1'b0;
    do_pulse(P_TRIG);
    wait_idle(4000);
    check("busy_width", last_w, 150);
    check("busy_ign", n_ign, i0 + 1);
    check("busy_one_echo", n_echo, e0 + 1);
    presente = 1'b1;

    // rise landing on the holdoff exit cycle is ignored
    distancia_cm = 9'd10;
    e0 = n_echo; i0 = n_ign;
    do_pulse(P_TRIG);
    wait_echo(1'b1, 200);
    wait_echo(1'b0, 200);
    repeat (P_HOLD - 3) @(negedge clock);
    trigger = 1'b1;
    repeat (P_TRIG) @(negedge clock);
    trigger = 1'b0;
    repeat (10) @(negedge clock);
    check("exit_edge_ign", n_ign, i0 + 1);
    check("exit_edge_no_echo", n_echo, e0 + 1);
    check("exit_edge_idle", ocupado, 0);

    // asynchronous reset in the middle of an echo
    distancia_cm = 9'd200;
    do_pulse(P_TRIG);
    wait_echo(1'b1, 200);
    repeat (30) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("async_reset_echo", echo, 0);
    check("async_reset_estado", db_estado, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("after_reset_estado", db_estado, 0);
    distancia_cm = 9'd30;
    e0 = n_echo;
    do_pulse(P_TRIG);
    wait_idle(4000);
    check("after_reset_width", last_w, 90);
    check("after_reset_one_echo", n_echo, e0 + 1);

    // randomized transactions checked by the model each cycle
    for (int k = 0; k < 16; k++) begin
      distancia_cm = 9'($urandom_range(0, 511));
      presente = ($urandom_range(0, 9) != 0);
      n = $urandom_range(P_TRIG - 4, P_TRIG + 6);
      do_pulse(n);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 400)) @(negedge clock);
        distancia_cm = 9'($urandom_range(0, 511));
        presente = ($urandom_range(0, 3) != 0);
        do_pulse($urandom_range(P_TRIG - 4, P_TRIG + 6));
      end
      wait_idle(4000);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
